// File: rtl/spi_rx_pkg.sv
// Shared defaults, SPI mode encoding and edge-selection helper for the SPI frame receiver.
package spi_rx_pkg;

    localparam int unsigned DefFrameBytes = 2;
    localparam int unsigned DefFifoDepth  = 4;
    localparam int unsigned DefSyncStages = 2;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling edge.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        spi_mode_e mode;
        mode = spi_mode_e'({cpol, cpha});
        return (mode == MODE0) || (mode == MODE3);
    endfunction

endpackage

// File: rtl/spi_frame_fifo.sv
// Show-ahead frame FIFO; a push into a full FIFO is accepted only if a pop happens the same cycle.
module spi_frame_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       ready,
    output logic                       valid,
    output logic [WIDTH-1:0]           data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       drop
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full, empty, pop, accept;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign pop    = ready & ~empty;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid = ~empty;
    assign data  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/synchronizer.sv
// Multi-flop synchroniser for a single asynchronous input, with selectable reset level.
module synchronizer #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: synchronises the SPI pins, assembles MSB-first frames and
// buffers them in a show-ahead FIFO with short-frame and overflow reporting.
module spi_frame_rx
    import spi_rx_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = DefFrameBytes,
    parameter int unsigned FIFO_DEPTH  = DefFifoDepth,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sck,
    input  logic                            sdi,
    input  logic                            cs_n,
    output logic                            frame_valid,
    output logic [8*FRAME_BYTES-1:0]        frame_data,
    input  logic                            frame_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            short_frame,
    output logic                            overflow,
    input  logic                            clear_err
);

    localparam int unsigned FW          = 8 * FRAME_BYTES;
    localparam int unsigned CNT_W       = $clog2(FW);
    localparam bit          SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic sck_sync, sdi_sync, cs_n_sync;

    synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sck (
        .clk   (clk),
        .reset (reset),
        .d     (sck),
        .q     (sck_sync)
    );

    synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk   (clk),
        .reset (reset),
        .d     (sdi),
        .q     (sdi_sync)
    );

    synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk   (clk),
        .reset (reset),
        .d     (cs_n),
        .q     (cs_n_sync)
    );

    logic             sck_prev_q, cs_n_prev_q;
    logic             sck_rise, sck_fall, sample;
    logic [FW-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             push_q, push_d;
    logic [FW-1:0]    push_data_q, push_data_d;
    logic             short_q, short_d;
    logic             overflow_q, overflow_d;
    logic             drop;

    assign sck_rise = sck_sync & ~sck_prev_q;
    assign sck_fall = ~sck_sync & sck_prev_q;
    assign sample   = SAMPLE_RISE ? sck_rise : sck_fall;

    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        short_d     = 1'b0;
        if (cs_n_sync) begin
            // Deselected: discard any partial frame; a sample edge in this cycle is ignored.
            shift_d   = '0;
            bit_cnt_d = '0;
            short_d   = ~cs_n_prev_q && (bit_cnt_q != '0);
        end else if (sample) begin
            shift_d = {shift_q[FW-2:0], sdi_sync};
            if (bit_cnt_q == CNT_W'(FW - 1)) begin
                bit_cnt_d   = '0;
                push_d      = 1'b1;
                push_data_d = shift_d;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_err) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_prev_q  <= CPOL;
            cs_n_prev_q <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            short_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sck_prev_q  <= sck_sync;
            cs_n_prev_q <= cs_n_sync;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            short_q     <= short_d;
            overflow_q  <= overflow_d;
        end
    end

    spi_frame_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (push_data_q),
        .ready     (frame_ready),
        .valid     (frame_valid),
        .data      (frame_data),
        .count     (fifo_count),
        .drop      (drop)
    );

    assign short_frame = short_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: one mode-0 unit under full test plus mode 1/2/3 and a
// deliberately misconfigured instance fed from the same SPI master.
module tb_spi_frame_rx;

    localparam int H = 8;
    localparam int N = 5;

    logic       clk = 1'b0;
    logic       reset, sck, sdi, cs_n, clear_err, ready_main;
    logic [4:0] sel;

    logic        vld [N];
    logic [15:0] dat [N];
    logic [2:0]  cnt [N];
    logic        sf  [N];
    logic        ovf [N];

    int          checks = 0;
    int          errors = 0;
    int          sf_cnt [N];
    logic [15:0] exp_q [N][$];

    always #5 clk = ~clk;

    // 0: mode 0 (main), 1: mode 1, 2: mode 2, 3: mode 3, 4: mode 0 fed a CPHA=1 stream
    spi_frame_rx #(.CPOL(1'b0), .CPHA(1'b0)) u_dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n | ~sel[0]),
        .frame_valid(vld[0]), .frame_data(dat[0]), .frame_ready(ready_main),
        .fifo_count(cnt[0]), .short_frame(sf[0]), .overflow(ovf[0]), .clear_err(clear_err)
    );

    spi_frame_rx #(.CPOL(1'b0), .CPHA(1'b1)) u_m1 (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n | ~sel[1]),
        .frame_valid(vld[1]), .frame_data(dat[1]), .frame_ready(1'b1),
        .fifo_count(cnt[1]), .short_frame(sf[1]), .overflow(ovf[1]), .clear_err(1'b0)
    );

    spi_frame_rx #(.CPOL(1'b1), .CPHA(1'b0)) u_m2 (
        .clk(clk), .reset(reset), .sck(~sck), .sdi(sdi), .cs_n(cs_n | ~sel[2]),
        .frame_valid(vld[2]), .frame_data(dat[2]), .frame_ready(1'b1),
        .fifo_count(cnt[2]), .short_frame(sf[2]), .overflow(ovf[2]), .clear_err(1'b0)
    );

    spi_frame_rx #(.CPOL(1'b1), .CPHA(1'b1)) u_m3 (
        .clk(clk), .reset(reset), .sck(~sck), .sdi(sdi), .cs_n(cs_n | ~sel[3]),
        .frame_valid(vld[3]), .frame_data(dat[3]), .frame_ready(1'b1),
        .fifo_count(cnt[3]), .short_frame(sf[3]), .overflow(ovf[3]), .clear_err(1'b0)
    );

    spi_frame_rx #(.CPOL(1'b0), .CPHA(1'b0)) u_bad (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n | ~sel[4]),
        .frame_valid(vld[4]), .frame_data(dat[4]), .frame_ready(1'b1),
        .fifo_count(cnt[4]), .short_frame(sf[4]), .overflow(ovf[4]), .clear_err(1'b0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Work done between the final sample edge of a frame and the next SCK edge.
    // 1: one-cycle ready pulse aligned with the FIFO push; 2: frame_valid latency check.
    task automatic after_edge(input int probe);
        ticks(3);
        if (probe == 1) begin
            ready_main = 1'b1;
        end else begin
            check("valid_latency_early", vld[0], 1'b0);
        end
        tick();
        if (probe == 1) begin
            ready_main = 1'b0;
        end else begin
            check("valid_latency_4", vld[0], 1'b1);
        end
        ticks(H - 4);
    endtask

    // CPHA=0 stream: data set half a period before the leading edge.
    // CPHA=1 stream: data changes 3 clk after the leading edge, sampled on the trailing edge.
    task automatic xfer(input logic [4:0] s, input bit cpha, input int nbits,
                        input logic [63:0] d, input int probe, input bit raise);
        logic b;
        sel  = s;
        cs_n = 1'b0;
        sdi  = 1'b0;
        ticks(H);
        for (int i = 0; i < nbits; i++) begin
            b = d[nbits-1-i];
            if (!cpha) begin
                sdi = b;
                ticks(H);
                sck = 1'b1;
                if (i == nbits - 1 && probe != 0) after_edge(probe);
                else ticks(H);
                sck = 1'b0;
            end else begin
                sck = 1'b1;
                ticks(3);
                sdi = b;
                ticks(H - 3);
                sck = 1'b0;
                ticks(H);
            end
        end
        if (raise) begin
            ticks(H);
            cs_n = 1'b1;
            ticks(2 * H);
        end
    endtask

    task automatic drain(input int n);
        ready_main = 1'b1;
        ticks(n + 2);
        ready_main = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin : monitor
        logic        r;
        logic [15:0] e;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                r = (i == 0) ? ready_main : 1'b1;
                if (vld[i] && r) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame dut%0d actual=%h required=none", i, dat[i]);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (dat[i] !== e) begin
                            errors++;
                            $display("FAIL frame_data dut%0d actual=%h required=%h", i, dat[i], e);
                        end
                    end
                end
                if (sf[i]) sf_cnt[i]++;
            end
        end
    end

    initial begin
        reset = 1'b1; sck = 1'b0; sdi = 1'b0; cs_n = 1'b1;
        clear_err = 1'b0; ready_main = 1'b0; sel = '0;
        for (int i = 0; i < N; i++) sf_cnt[i] = 0;
        ticks(4);
        check("rst_valid", vld[0], 1'b0);
        check("rst_data", dat[0], 16'h0000);
        check("rst_count", cnt[0], 3'd0);
        check("rst_short", sf[0], 1'b0);
        check("rst_overflow", ovf[0], 1'b0);
        reset = 1'b0;
        ticks(4);

        // Mode 0 single frame with latency probe, then one pop.
        exp_q[0].push_back(16'hA53C);
        xfer(5'b00001, 1'b0, 16, 64'hA53C, 2, 1'b1);
        check("single_count", cnt[0], 3'd1);
        ready_main = 1'b1;
        tick();
        ready_main = 1'b0;
        tick();
        check("pop_count", cnt[0], 3'd0);
        check("pop_valid", vld[0], 1'b0);

        // Other modes; the misconfigured unit sees every bit one position late.
        exp_q[2].push_back(16'hA53C);
        xfer(5'b00100, 1'b0, 16, 64'hA53C, 0, 1'b1);
        exp_q[1].push_back(16'hA53C);
        exp_q[3].push_back(16'hA53C);
        exp_q[4].push_back(16'h529E);
        xfer(5'b11010, 1'b1, 16, 64'hA53C, 0, 1'b1);
        ticks(4);

        // Burst of three frames in one chip-select window.
        exp_q[0].push_back(16'h0102);
        exp_q[0].push_back(16'h0304);
        exp_q[0].push_back(16'h0506);
        xfer(5'b00001, 1'b0, 48, 64'h010203040506, 0, 1'b1);
        check("burst_count", cnt[0], 3'd3);
        drain(3);
        check("burst_drained", cnt[0], 3'd0);

        // Five frames into a depth-4 FIFO: the fifth is dropped.
        for (int k = 1; k <= 4; k++) begin
            exp_q[0].push_back(16'(16'h1111 * k));
            xfer(5'b00001, 1'b0, 16, 64'(16'h1111 * k), 0, 1'b1);
        end
        xfer(5'b00001, 1'b0, 16, 64'h5555, 0, 1'b1);
        check("ovf_set", ovf[0], 1'b1);
        check("ovf_count", cnt[0], 3'd4);
        ticks(3);
        check("ovf_sticky", ovf[0], 1'b1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("ovf_cleared", ovf[0], 1'b0);
        drain(4);
        check("ovf_drained", cnt[0], 3'd0);

        // Same again, but a pop coincides with the fifth push: nothing lost.
        for (int k = 6; k <= 9; k++) begin
            exp_q[0].push_back(16'(16'h1111 * k));
            xfer(5'b00001, 1'b0, 16, 64'(16'h1111 * k), 0, 1'b1);
        end
        exp_q[0].push_back(16'hAAAA);
        xfer(5'b00001, 1'b0, 16, 64'hAAAA, 1, 1'b1);
        check("nopop_ovf", ovf[0], 1'b0);
        check("nopop_count", cnt[0], 3'd4);
        drain(4);
        check("nopop_drained", cnt[0], 3'd0);

        // Short frame of 11 bits, then a good frame.
        xfer(5'b00001, 1'b0, 11, 64'h5A3, 0, 1'b1);
        check("short_pulses", sf_cnt[0], 1);
        check("short_count", cnt[0], 3'd0);
        exp_q[0].push_back(16'hBEEF);
        xfer(5'b00001, 1'b0, 16, 64'hBEEF, 0, 1'b1);
        drain(1);

        // Reset mid-frame with a frame still buffered.
        exp_q[0].push_back(16'h7777);
        xfer(5'b00001, 1'b0, 16, 64'h7777, 0, 1'b1);
        check("pre_reset_count", cnt[0], 3'd1);
        xfer(5'b00001, 1'b0, 6, 64'h2A, 0, 1'b0);
        reset = 1'b1;
        ticks(2);
        check("midrst_valid", vld[0], 1'b0);
        check("midrst_data", dat[0], 16'h0000);
        check("midrst_count", cnt[0], 3'd0);
        check("midrst_short", sf[0], 1'b0);
        check("midrst_overflow", ovf[0], 1'b0);
        exp_q[0].delete();
        reset = 1'b0;
        cs_n  = 1'b1;
        ticks(2 * H);
        exp_q[0].push_back(16'h1234);
        xfer(5'b00001, 1'b0, 16, 64'h1234, 0, 1'b1);
        drain(1);

        for (int i = 0; i < N; i++) begin
            check($sformatf("queue_empty_dut%0d", i), exp_q[i].size(), 0);
            check($sformatf("short_total_dut%0d", i), sf_cnt[i], (i == 0) ? 1 : 0);
            check($sformatf("final_count_dut%0d", i), cnt[i], 3'd0);
            if (i != 0) check($sformatf("final_ovf_dut%0d", i), ovf[i], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
